// File: rtl/idct_col_stream.sv
// idct_col_stream: serial column inverse transform for 4-point and 8-point
// HEVC blocks. Coefficients x[k] arrive one per handshake. They are
// multiplied by the transform matrix using shift-add constant multipliers and
// accumulated into N running sums. The finished column is rounded, shifted,
// saturated and parked in an output buffer. That buffer drains one sample per
// handshake while the next column accumulates.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   coefficient handshake
//   in_data             signed coefficient, k ascending from 0
//   in_size             0 = 4-point, 1 = 8-point (sampled at k == 0 only)
//   out_valid/out_ready sample handshake
//   out_data            signed residual sample, i ascending from 0
//   out_last            marks y[N-1]
//   out_sat             current out_data was clipped
//
// Input FSM:
//   state | meaning
//   ACC   | accepting coefficients into the accumulators
//   DONE  | column complete, waiting for the output buffer to free up
module idct_col_stream #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 16,
  parameter int WIDTH_ACC = 26,
  parameter int SHIFT     = 7,
  parameter int ROUND     = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH_IN-1:0]  in_data,
  input  logic                        in_size,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic                        out_last,
  output logic                        out_sat
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  // 4-point matrix rows are the even rows of the 8-point matrix (first 4 columns).
  localparam logic signed [7:0] T8 [8][8] = '{
    '{8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
    '{8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
    '{8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
    '{8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
    '{8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
    '{8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
  };

  localparam logic signed [WIDTH_ACC-1:0] RND     = WIDTH_ACC'(ROUND);
  localparam logic signed [WIDTH_ACC-1:0] OUT_MAX = WIDTH_ACC'((1 << (WIDTH_OUT-1)) - 1);
  localparam logic signed [WIDTH_ACC-1:0] OUT_MIN = ~OUT_MAX;

  state_t state, state_nxt;
  logic [2:0] k;
  logic       size_acc;
  logic signed [WIDTH_ACC-1:0] acc  [8];
  logic signed [WIDTH_ACC-1:0] term [8];

  logic signed [WIDTH_OUT-1:0] buf_data [8];
  logic [7:0] buf_sat;
  logic       size_buf;
  logic       buf_full;
  logic [2:0] j;

  logic signed [WIDTH_OUT-1:0] clip_data [8];
  logic [7:0] clip_sat;

  logic in_hs, out_hs, size_cur, last_in, drain_last, load;
  logic [2:0] row, last_idx;

  assign in_hs      = in_valid & in_ready;
  assign out_hs     = buf_full & out_ready;
  // The first coefficient carries the size; later ones use the latched copy.
  assign size_cur   = (k == 3'd0) ? in_size : size_acc;
  assign last_in    = (k == (size_cur ? 3'd7 : 3'd3));
  assign row        = size_cur ? k : {k[1:0], 1'b0};
  assign last_idx   = size_buf ? 3'd7 : 3'd3;
  assign drain_last = out_hs && (j == last_idx);

  // Shift-add products of the coefficient with every matrix magnitude.
  logic signed [WIDTH_ACC-1:0] xe, p18, p36, p50, p64, p75, p83, p89;
  assign xe  = in_data;
  assign p18 = (xe <<< 4) + (xe <<< 1);
  assign p36 = (xe <<< 5) + (xe <<< 2);
  assign p50 = (xe <<< 5) + (xe <<< 4) + (xe <<< 1);
  assign p64 = (xe <<< 6);
  assign p75 = (xe <<< 6) + (xe <<< 3) + (xe <<< 1) + xe;
  assign p83 = (xe <<< 6) + (xe <<< 4) + (xe <<< 1) + xe;
  assign p89 = (xe <<< 6) + (xe <<< 4) + (xe <<< 3) + xe;

  always_comb begin
    logic signed [7:0]           coef;
    logic [7:0]                  mag;
    logic signed [WIDTH_ACC-1:0] prod;
    coef = '0;
    mag  = '0;
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      coef = T8[row][i];
      mag  = coef[7] ? -coef : coef;
      case (mag)
        8'd18:   prod = p18;
        8'd36:   prod = p36;
        8'd50:   prod = p50;
        8'd75:   prod = p75;
        8'd83:   prod = p83;
        8'd89:   prod = p89;
        default: prod = p64;
      endcase
      term[i] = coef[7] ? -prod : prod;
    end
  end

  always_comb begin
    logic signed [WIDTH_ACC-1:0] scaled;
    scaled   = '0;
    clip_sat = '0;
    for (int i = 0; i < 8; i++) begin
      // Arithmetic shift: negative sums round toward -inf after the offset.
      scaled = (acc[i] + RND) >>> SHIFT;
      if (scaled > OUT_MAX) begin
        clip_data[i] = OUT_MAX[WIDTH_OUT-1:0];
        clip_sat[i]  = 1'b1;
      end else if (scaled < OUT_MIN) begin
        clip_data[i] = OUT_MIN[WIDTH_OUT-1:0];
        clip_sat[i]  = 1'b1;
      end else begin
        clip_data[i] = scaled[WIDTH_OUT-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_hs && last_in) state_nxt = DONE;
      end
      DONE: begin
        // Reload may coincide with the final drain handshake, avoiding a bubble.
        load = !buf_full || drain_last;
        if (load) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      k        <= '0;
      size_acc <= 1'b0;
      for (int i = 0; i < 8; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      if (in_hs) begin
        k <= last_in ? 3'd0 : k + 3'd1;
        if (k == 3'd0) size_acc <= in_size;
        for (int i = 0; i < 8; i++)
          acc[i] <= ((k == 3'd0) ? '0 : acc[i]) + term[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) buf_data[i] <= '0;
      buf_sat  <= '0;
      size_buf <= 1'b0;
      buf_full <= 1'b0;
      j        <= '0;
    end else if (load) begin
      for (int i = 0; i < 8; i++) buf_data[i] <= clip_data[i];
      buf_sat  <= clip_sat;
      size_buf <= size_acc;
      buf_full <= 1'b1;
      j        <= '0;
    end else if (out_hs) begin
      if (j == last_idx) begin
        buf_full <= 1'b0;
        j        <= '0;
      end else begin
        j <= j + 3'd1;
      end
    end
  end

  assign out_valid = buf_full;
  assign out_data  = buf_data[j];
  assign out_last  = buf_full && (j == last_idx);
  assign out_sat   = buf_full & buf_sat[j];

endmodule
